alu_cmd_issuer: RTL and testbench

Initiator side of the ALU start/done interface. Accepts tagged operation commands on a valid/ready port and drives A/B/opcode/start into the ALU. Waits for done, captures the 16-bit result and returns it with its tag on a valid/ready response port. Sits between the test/host sequencer and the ALU; one operation in flight at a time.

---
 rtl/alu_cmd_issuer.sv | 123 ++++++++++++
 tb/tb_alu_cmd_issuer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of the ALU start/done handshake.
// Takes tagged commands on a valid/ready port, drives operands, opcode and
// a one-cycle start pulse into the ALU, waits for done, and returns the
// 16-bit result with its tag on a valid/ready response port. One operation
// is in flight at a time.
//
// Optional feature macro: ALU_TIMEOUT_EN
//   When defined, WAIT is bounded to TIMEOUT_CYCLES cycles. On expiry the
//   response carries 16'hDEAD with rsp_err = 1.
//   When undefined, WAIT is unbounded and rsp_err is constant 0.
//
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   cmd_valid/ready, cmd_a/b/op/tag  command port
//   alu_a/b/opcode, alu_start      ALU drive (operands held until next accept)
//   alu_result, alu_done           ALU completion
//   rsp_valid/ready, rsp_result/tag/err  response port
//   op_count                       completed responses, wraps at 16 bits
module alu_cmd_issuer #(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_start,
  input  logic [15:0]      alu_result,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             timeout;

  assign accept    = cmd_valid & cmd_ready;
  assign alu_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign rsp_tag   = tag_q;

`ifdef ALU_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        err_q;

  // Counter sits at 0 outside WAIT, so the first WAIT cycle sees 0 and the
  // TIMEOUT_CYCLES-th WAIT cycle sees TIMEOUT_CYCLES-1. Done wins a tie.
  assign timeout = (state == WAIT) && !alu_done &&
                   (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 16'd1 : 16'd0;
      if (accept)       err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      // The ALU never raises done for a nop, so skip WAIT entirely.
      ISSUE: state_nxt = (alu_opcode == 3'd0) ? RESP : WAIT;
      WAIT:  if (alu_done || timeout) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      tag_q      <= '0;
      rsp_result <= '0;
      op_count   <= '0;
    end else begin
      state     <= state_nxt;
      // Registered ready: high exactly while the FSM sits in IDLE.
      cmd_ready <= (state_nxt == IDLE);
      if (accept) begin
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_opcode <= cmd_op;
        tag_q      <= cmd_tag;
      end
      if (state == ISSUE && alu_opcode == 3'd0) rsp_result <= 16'h0000;
      else if (state == WAIT && alu_done)       rsp_result <= alu_result;
      else if (timeout)                         rsp_result <= 16'hDEAD;
      if (state == RESP && rsp_ready) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;
  localparam int TAG_W = 4;
`ifdef ALU_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = '0, cmd_b = '0;
  logic [2:0]       cmd_op = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [7:0]       alu_a, alu_b;
  logic [2:0]       alu_opcode;
  logic             alu_start;
  logic [15:0]      alu_result;
  logic             alu_done;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic [15:0]      op_count;

  int total = 0;
  int bad   = 0;

  // Behavioural ALU: result is combinational on the held operands; done
  // one cycle after start for ops 1-3, four cycles after start for multiply.
  logic       alu_en = 1'b1;
  logic       inject_done = 1'b0;
  logic       auto_done = 1'b0;
  logic [2:0] mulcnt = '0;

  assign alu_done = auto_done | inject_done;

  always_comb begin
    case (alu_opcode)
      3'd1:    alu_result = {8'h00, alu_a} + {8'h00, alu_b};
      3'd2:    alu_result = {8'h00, alu_a & alu_b};
      3'd3:    alu_result = {8'h00, alu_a ^ alu_b};
      3'd0:    alu_result = 16'h0000;
      default: alu_result = alu_a * alu_b;
    endcase
  end

  always @(posedge clk) begin
    auto_done <= 1'b0;
    if (!rst_n) begin
      mulcnt <= '0;
    end else if (alu_start && alu_en) begin
      if (alu_opcode >= 3'd1 && alu_opcode <= 3'd3) auto_done <= 1'b1;
      else if (alu_opcode >= 3'd4)                  mulcnt <= 3'd3;
    end else if (mulcnt != 3'd0) begin
      mulcnt <= mulcnt - 3'd1;
      if (mulcnt == 3'd1) auto_done <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  alu_cmd_issuer #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command with rsp_ready high. lat counts cycles from the
  // handshake cycle (0) to the first rsp_valid cycle; -1 on timeout.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag,
                        output int lat, output logic [15:0] res,
                        output logic [TAG_W-1:0] rtag, output logic err,
                        output logic busy_ok, output logic hold_ok,
                        output int done_cyc, output int start_cnt);
    int w;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    w = 0;
    while (!cmd_ready && w < 50) begin step(); w++; end
    step();
    cmd_valid = 1'b0;
    lat = 1; busy_ok = 1'b1; hold_ok = 1'b1; done_cyc = -1; start_cnt = 0;
    while (!rsp_valid && lat < 200) begin
      if (cmd_ready) busy_ok = 1'b0;
      if (alu_a !== a || alu_b !== b || alu_opcode !== op) hold_ok = 1'b0;
      if (alu_start) start_cnt++;
      if (alu_done && done_cyc < 0) done_cyc = lat;
      step();
      lat++;
    end
    if (cmd_ready) busy_ok = 1'b0;
    if (alu_a !== a || alu_b !== b || alu_opcode !== op) hold_ok = 1'b0;
    if (lat >= 200) lat = -1;
    res = rsp_result; rtag = rsp_tag; err = rsp_err;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++;
    if ({cmd_ready, alu_start, rsp_valid, rsp_err} !== 4'b0 ||
        {alu_a, alu_b, alu_opcode} !== 19'h0 || rsp_result !== 16'h0 ||
        rsp_tag !== 4'h0 || op_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b st=%b vld=%b err=%b a=%h b=%h op=%h res=%h tag=%h cnt=%h, all zero required",
               cmd_ready, alu_start, rsp_valid, rsp_err, alu_a, alu_b, alu_opcode, rsp_result, rsp_tag, op_count);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_first_idle_ready: got %b want 0", cmd_ready); end
    step();
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise: got %b want 1", cmd_ready); end
  endtask

  task automatic test_add();
    int lat, dc, sc; logic [15:0] r; logic [TAG_W-1:0] t; logic e, bz, hd;
    run_op(8'hFF, 8'h01, 3'd1, 4'd3, lat, r, t, e, bz, hd, dc, sc);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL add_latency: got %0d want 3", lat); end
    total++;
    if (sc !== 1) begin bad++; $display("FAIL add_start_pulses: got %0d want 1", sc); end
    total++;
    if (r !== 16'h0100 || t !== 4'd3 || e !== 1'b0) begin
      bad++; $display("FAIL add_rsp: res=%h tag=%h err=%b want 0100/3/0", r, t, e);
    end
    total++;
    if (op_count !== 16'd1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL add_after: cnt=%0d vld=%b rdy=%b want 1/0/1", op_count, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int l1, l2, dc, sc; logic [15:0] r1, r2; logic [TAG_W-1:0] t1, t2;
    logic e, b1, b2, hd;
    run_op(8'hF0, 8'h3C, 3'd2, 4'd5, l1, r1, t1, e, b1, hd, dc, sc);
    run_op(8'hF0, 8'h3C, 3'd3, 4'd6, l2, r2, t2, e, b2, hd, dc, sc);
    total++;
    if (r1 !== 16'h0030 || t1 !== 4'd5) begin bad++; $display("FAIL b2b_and: res=%h tag=%h want 0030/5", r1, t1); end
    total++;
    if (r2 !== 16'h00CC || t2 !== 4'd6) begin bad++; $display("FAIL b2b_xor: res=%h tag=%h want 00CC/6", r2, t2); end
    total++;
    if (l1 !== 3 || l2 !== 3) begin bad++; $display("FAIL b2b_latency: got %0d,%0d want 3,3", l1, l2); end
    total++;
    if (!b1 || !b2) begin bad++; $display("FAIL b2b_ready_busy: got %b%b want 11", b1, b2); end
    total++;
    if (op_count !== 16'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", op_count); end
  endtask

  task automatic test_multiply();
    int lat, dc, sc; logic [15:0] r; logic [TAG_W-1:0] t; logic e, bz, hd;
    run_op(8'hFF, 8'hFF, 3'd4, 4'd7, lat, r, t, e, bz, hd, dc, sc);
    total++;
    if (r !== 16'hFE01 || t !== 4'd7) begin bad++; $display("FAIL mul_rsp: res=%h tag=%h want FE01/7", r, t); end
    total++;
    if (dc !== 5 || lat !== 6) begin bad++; $display("FAIL mul_timing: done=%0d valid=%0d want 5/6", dc, lat); end
    total++;
    if (!hd) begin bad++; $display("FAIL mul_operand_hold: got %b want 1", hd); end
  endtask

  task automatic test_nop();
    int lat, dc, sc; logic [15:0] r; logic [TAG_W-1:0] t; logic e, bz, hd;
    inject_done = 1'b1;
    step();
    inject_done = 1'b0;
    step();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 16'd4) begin
      bad++; $display("FAIL idle_spurious_done: vld=%b rdy=%b cnt=%0d want 0/1/4", rsp_valid, cmd_ready, op_count);
    end
    run_op(8'h12, 8'h34, 3'd0, 4'd9, lat, r, t, e, bz, hd, dc, sc);
    total++;
    if (lat !== 2 || r !== 16'h0000 || t !== 4'd9) begin
      bad++; $display("FAIL nop_rsp: lat=%0d res=%h tag=%h want 2/0000/9", lat, r, t);
    end
  endtask

  task automatic test_hold_and_reset();
    int w;
    logic ok;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 8'h01; cmd_b = 8'h02; cmd_op = 3'd1; cmd_tag = 4'hA;
    w = 0;
    while (!cmd_ready && w < 50) begin step(); w++; end
    step();
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 50) begin step(); w++; end
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h0003 || rsp_tag !== 4'hA ||
          cmd_ready !== 1'b0 || op_count !== 16'd5) ok = 1'b0;
      step();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rsp_hold: vld=%b res=%h tag=%h rdy=%b cnt=%0d want 1/0003/A/0/5", rsp_valid, rsp_result, rsp_tag, cmd_ready, op_count); end
    rsp_ready = 1'b1;
    step();
    total++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd6) begin
      bad++; $display("FAIL rsp_release: vld=%b cnt=%0d want 0/6", rsp_valid, op_count);
    end
    // Reset in the middle of a multiply's WAIT.
    cmd_valid = 1'b1; cmd_a = 8'h02; cmd_b = 8'h03; cmd_op = 3'd5; cmd_tag = 4'h1;
    w = 0;
    while (!cmd_ready && w < 50) begin step(); w++; end
    step();
    cmd_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, alu_start, rsp_valid, rsp_err} !== 4'b0 ||
        {alu_a, alu_b, alu_opcode} !== 19'h0 || rsp_result !== 16'h0 ||
        rsp_tag !== 4'h0 || op_count !== 16'h0) begin
      bad++;
      $display("FAIL midop_reset: rdy=%b st=%b vld=%b a=%h b=%h op=%h res=%h tag=%h cnt=%h, all zero required",
               cmd_ready, alu_start, rsp_valid, alu_a, alu_b, alu_opcode, rsp_result, rsp_tag, op_count);
    end
    step(); step();
    rst_n = 1'b1;
    inject_done = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 2) inject_done = 1'b0;
      if (rsp_valid !== 1'b0 || alu_start !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok || op_count !== 16'd0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL late_done_ignored: ok=%b cnt=%0d rdy=%b want 1/0/1", ok, op_count, cmd_ready);
    end
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout();
    int lat, dc, sc; logic [15:0] r; logic [TAG_W-1:0] t; logic e, bz, hd;
    alu_en = 1'b0;
    run_op(8'h01, 8'h01, 3'd1, 4'd2, lat, r, t, e, bz, hd, dc, sc);
    total++;
    if (lat !== 10 || r !== 16'hDEAD || e !== 1'b1 || t !== 4'd2) begin
      bad++; $display("FAIL timeout_rsp: lat=%0d res=%h err=%b tag=%h want 10/DEAD/1/2", lat, r, e, t);
    end
    total++;
    if (rsp_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky: got %b want 1", rsp_err); end
    alu_en = 1'b1;
    run_op(8'h01, 8'h01, 3'd1, 4'd4, lat, r, t, e, bz, hd, dc, sc);
    total++;
    if (lat !== 3 || r !== 16'h0002 || e !== 1'b0) begin
      bad++; $display("FAIL timeout_clear: lat=%0d res=%h err=%b want 3/0002/0", lat, r, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_multiply();
    test_nop();
    test_hold_and_reset();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
